// File: rtl/process_scheduler_if.sv
// Scheduler <-> processor bus: control/context inputs from the CPU side,
// PC-override and status outputs from the scheduler.
interface process_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int NPROC  = 4,
  parameter int PID_W  = 2
);
  logic              Enable;
  logic [DATA_W-1:0] CurrentPC;
  logic              Create;
  logic [PID_W-1:0]  CreatePID;
  logic [DATA_W-1:0] CreatePC;
  logic              Kill;
  logic              Yield;
  logic              PCLoad;
  logic [DATA_W-1:0] PCOut;
  logic [PID_W-1:0]  RunningPID;
  logic [DATA_W-1:0] MemOffset;
  logic [NPROC-1:0]  ReadyMask;
  logic              Idle;
  logic              Switching;

  modport master (
    output Enable, CurrentPC, Create, CreatePID, CreatePC, Kill, Yield,
    input  PCLoad, PCOut, RunningPID, MemOffset, ReadyMask, Idle, Switching
  );

  modport slave (
    input  Enable, CurrentPC, Create, CreatePID, CreatePC, Kill, Yield,
    output PCLoad, PCOut, RunningPID, MemOffset, ReadyMask, Idle, Switching
  );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin preemptive process scheduler: saves/restores per-process PCs
// and drives the per-process data-memory partition offset.
module process_scheduler #(
  parameter int DATA_W     = 32,
  parameter int NPROC      = 4,
  parameter int PID_W      = 2,
  parameter int QUANTUM    = 64,
  parameter int PAGE_WORDS = 256
) (
  input  logic               Clock,
  input  logic               Reset,
  process_scheduler_if.slave sch
);
  // state  | meaning
  // IDLE   | no process running, waiting for Enable and a ready slot
  // RUN    | process running, quantum counting
  // SAVE   | store exit PC or retire killed slot
  // SELECT | round-robin search for the next ready slot
  // LOAD   | PCLoad pulse with restored PC
  localparam int CNT_W = $clog2(QUANTUM);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SAVE, S_SELECT, S_LOAD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] table_q [NPROC];
  logic [DATA_W-1:0] table_d [NPROC];
  logic [NPROC-1:0]  ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PID_W-1:0]  pid_q, pid_d;
  logic [DATA_W-1:0] memoff_q, memoff_d;
  logic [DATA_W-1:0] pcout_q, pcout_d;
  logic [DATA_W-1:0] exit_pc_q, exit_pc_d;
  logic              kill_q, kill_d;

  logic              create_ok;
  logic              exit_req;
  logic              found;
  logic [PID_W-1:0]  sel;
  logic [DATA_W-1:0] sel_pc;
  int                idx;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < NPROC; i++) table_q[i] <= '0;
      ready_q   <= '0;
      cnt_q     <= '0;
      pid_q     <= '0;
      memoff_q  <= '0;
      pcout_q   <= '0;
      exit_pc_q <= '0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < NPROC; i++) table_q[i] <= table_d[i];
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      pid_q     <= pid_d;
      memoff_q  <= memoff_d;
      pcout_q   <= pcout_d;
      exit_pc_q <= exit_pc_d;
      kill_q    <= kill_d;
    end
  end

  // The running slot's context belongs to the save path while in RUN/SAVE.
  assign create_ok = sch.Create && (int'(sch.CreatePID) < NPROC) &&
                     !((sch.CreatePID == pid_q) && (state_q == S_RUN || state_q == S_SAVE));

  assign exit_req = (state_q == S_RUN) &&
                    (sch.Kill || sch.Yield || (sch.Enable && cnt_q == CNT_W'(QUANTUM - 1)));

  always_comb begin
    table_d   = table_q;
    ready_d   = ready_q;
    cnt_d     = cnt_q;
    pid_d     = pid_q;
    memoff_d  = memoff_q;
    pcout_d   = pcout_q;
    exit_pc_d = exit_pc_q;
    kill_d    = kill_q;
    found     = 1'b0;
    sel       = '0;
    sel_pc    = '0;
    idx       = 0;

    for (int i = 0; i < NPROC; i++) begin
      if (state_q == S_SAVE && pid_q == PID_W'(i)) begin
        if (kill_q) ready_d[i] = 1'b0;
        else        table_d[i] = exit_pc_q;
      end
      if (create_ok && sch.CreatePID == PID_W'(i)) begin
        table_d[i] = sch.CreatePC;
        ready_d[i] = 1'b1;
      end
    end

    // Searching the _d view lets a same-cycle Create take part in SELECT.
    for (int i = 1; i <= NPROC; i++) begin
      idx = (int'(pid_q) + i) % NPROC;
      if (!found && ready_d[idx]) begin
        found  = 1'b1;
        sel    = PID_W'(idx);
        sel_pc = table_d[idx];
      end
    end

    case (state_q)
      S_RUN: begin
        if (exit_req) begin
          exit_pc_d = sch.CurrentPC;
          kill_d    = sch.Kill;
        end else if (sch.Enable) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SELECT: begin
        if (found) begin
          pid_d    = sel;
          memoff_d = DATA_W'(sel) * DATA_W'(PAGE_WORDS);
          pcout_d  = sel_pc;
        end
      end
      S_LOAD:  cnt_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sch.Enable && |ready_q) state_d = S_SELECT;
      S_RUN:    if (exit_req) state_d = S_SAVE;
      S_SAVE:   state_d = S_SELECT;
      S_SELECT: state_d = found ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sch.PCLoad    = (state_q == S_LOAD);
    sch.Idle      = (state_q == S_IDLE);
    sch.Switching = (state_q == S_SAVE) || (state_q == S_SELECT) || (state_q == S_LOAD);
  end

  assign sch.PCOut      = pcout_q;
  assign sch.RunningPID = pid_q;
  assign sch.MemOffset  = memoff_q;
  assign sch.ReadyMask  = ready_q;
endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: a 4-slot and a 5-slot instance,
// QUANTUM=8, PAGE_WORDS=256, checked against hand-computed values.
module tb_process_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt_sw;
  int   cnt_pl;

  always #5 clk = ~clk;

  process_scheduler_if #(.DATA_W(32), .NPROC(4), .PID_W(2)) bus4 ();
  process_scheduler_if #(.DATA_W(32), .NPROC(5), .PID_W(3)) bus5 ();

  process_scheduler #(.DATA_W(32), .NPROC(4), .PID_W(2), .QUANTUM(8), .PAGE_WORDS(256)) dut4 (
    .Clock(clk), .Reset(rst), .sch(bus4.slave));

  process_scheduler #(.DATA_W(32), .NPROC(5), .PID_W(3), .QUANTUM(8), .PAGE_WORDS(256)) dut5 (
    .Clock(clk), .Reset(rst), .sch(bus5.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus4.Enable = 0; bus4.CurrentPC = '0; bus4.Create = 0; bus4.CreatePID = '0;
    bus4.CreatePC = '0; bus4.Kill = 0; bus4.Yield = 0;
    bus5.Enable = 0; bus5.CurrentPC = '0; bus5.Create = 0; bus5.CreatePID = '0;
    bus5.CreatePC = '0; bus5.Kill = 0; bus5.Yield = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic create4(input logic [1:0] pid, input logic [31:0] pc);
    bus4.Create = 1; bus4.CreatePID = pid; bus4.CreatePC = pc;
    step();
    bus4.Create = 0;
  endtask

  initial begin
    idle_inputs();

    // reset values
    do_reset();
    chk("rst_idle", 64'(bus4.Idle), 64'd1);
    chk("rst_switching", 64'(bus4.Switching), 64'd0);
    chk("rst_pcload", 64'(bus4.PCLoad), 64'd0);
    chk("rst_pid", 64'(bus4.RunningPID), 64'd0);
    chk("rst_memoff", 64'(bus4.MemOffset), 64'd0);
    chk("rst_pcout", 64'(bus4.PCOut), 64'd0);
    chk("rst_ready", 64'(bus4.ReadyMask), 64'd0);

    // first dispatch: create PID1 then enable
    create4(2'd1, 32'h40);
    chk("c1_ready", 64'(bus4.ReadyMask), 64'b0010);
    chk("c1_still_idle", 64'(bus4.Idle), 64'd1);
    bus4.Enable = 1;
    step();
    chk("c1_select_sw", 64'(bus4.Switching), 64'd1);
    chk("c1_select_pl", 64'(bus4.PCLoad), 64'd0);
    step();
    chk("c1_load_pl", 64'(bus4.PCLoad), 64'd1);
    chk("c1_load_pc", 64'(bus4.PCOut), 64'h40);
    chk("c1_load_pid", 64'(bus4.RunningPID), 64'd1);
    chk("c1_load_off", 64'(bus4.MemOffset), 64'd256);
    step();
    chk("c1_run_pl", 64'(bus4.PCLoad), 64'd0);
    chk("c1_run_sw", 64'(bus4.Switching), 64'd0);
    chk("c1_run_pchold", 64'(bus4.PCOut), 64'h40);

    // quantum expiry PID0 -> PID2, then kill PID2 -> PID0 restored at saved PC
    do_reset();
    create4(2'd0, 32'h10);
    bus4.Enable = 1;
    step();
    step();
    chk("q_load0_pc", 64'(bus4.PCOut), 64'h10);
    chk("q_load0_pid", 64'(bus4.RunningPID), 64'd0);
    bus4.Create = 1; bus4.CreatePID = 2'd2; bus4.CreatePC = 32'h80;
    bus4.CurrentPC = 32'h17;
    step();
    bus4.Create = 0;
    chk("q_ready", 64'(bus4.ReadyMask), 64'b0101);
    repeat (7) step();
    chk("q_last_run", 64'(bus4.Switching), 64'd0);
    step();
    chk("q_save", 64'(bus4.Switching), 64'd1);
    step();
    step();
    chk("q_load2_pl", 64'(bus4.PCLoad), 64'd1);
    chk("q_load2_pc", 64'(bus4.PCOut), 64'h80);
    chk("q_load2_pid", 64'(bus4.RunningPID), 64'd2);
    chk("q_load2_off", 64'(bus4.MemOffset), 64'd512);
    step();
    bus4.Kill = 1;
    step();
    bus4.Kill = 0;
    step();
    chk("q_kill2_ready", 64'(bus4.ReadyMask), 64'b0001);
    step();
    chk("q_reload0_pc", 64'(bus4.PCOut), 64'h17);
    chk("q_reload0_pid", 64'(bus4.RunningPID), 64'd0);

    // lone PID3 yields; create on running PID is ignored
    do_reset();
    create4(2'd3, 32'h30);
    bus4.Enable = 1;
    step();
    step();
    chk("y_load3_pc", 64'(bus4.PCOut), 64'h30);
    step();
    bus4.CurrentPC = 32'h99; bus4.Yield = 1;
    bus4.Create = 1; bus4.CreatePID = 2'd3; bus4.CreatePC = 32'h77;
    step();
    bus4.Yield = 0; bus4.Create = 0;
    step();
    step();
    chk("y_reload_pl", 64'(bus4.PCLoad), 64'd1);
    chk("y_reload_pc", 64'(bus4.PCOut), 64'h99);
    chk("y_reload_pid", 64'(bus4.RunningPID), 64'd3);
    chk("y_reload_off", 64'(bus4.MemOffset), 64'd768);
    chk("y_reload_ready", 64'(bus4.ReadyMask), 64'b1000);

    // kill + yield together on the only process -> idle
    do_reset();
    create4(2'd1, 32'h40);
    bus4.Enable = 1;
    step();
    step();
    step();
    bus4.Kill = 1; bus4.Yield = 1; bus4.CurrentPC = 32'h55;
    step();
    bus4.Kill = 0; bus4.Yield = 0;
    step();
    chk("ky_ready", 64'(bus4.ReadyMask), 64'b0000);
    chk("ky_select_sw", 64'(bus4.Switching), 64'd1);
    step();
    chk("ky_idle", 64'(bus4.Idle), 64'd1);
    chk("ky_no_pl", 64'(bus4.PCLoad), 64'd0);
    step();
    chk("ky_idle_hold", 64'(bus4.Idle), 64'd1);
    chk("ky_no_pl_hold", 64'(bus4.PCLoad), 64'd0);

    // create during SELECT is seen by that search
    do_reset();
    create4(2'd1, 32'h40);
    bus4.Enable = 1;
    step();
    step();
    step();
    bus4.Kill = 1;
    step();
    bus4.Kill = 0;
    step();
    bus4.Create = 1; bus4.CreatePID = 2'd2; bus4.CreatePC = 32'h20;
    step();
    bus4.Create = 0;
    chk("cs_load_pl", 64'(bus4.PCLoad), 64'd1);
    chk("cs_load_pc", 64'(bus4.PCOut), 64'h20);
    chk("cs_load_pid", 64'(bus4.RunningPID), 64'd2);

    // Enable low in RUN freezes the quantum
    do_reset();
    create4(2'd0, 32'h10);
    bus4.Enable = 1;
    step();
    step();
    step();
    bus4.Enable = 0;
    cnt_sw = 0;
    repeat (20) begin
      step();
      if (bus4.Switching) cnt_sw++;
    end
    chk("en_hold_no_preempt", 64'(cnt_sw), 64'd0);
    bus4.Enable = 1;
    repeat (7) step();
    chk("en_resume_run", 64'(bus4.Switching), 64'd0);
    step();
    chk("en_resume_save", 64'(bus4.Switching), 64'd1);

    // reset during SELECT discards the switch
    do_reset();
    create4(2'd1, 32'h40);
    bus4.Enable = 1;
    step();
    chk("rs_in_select", 64'(bus4.Switching), 64'd1);
    rst = 1'b1;
    #1;
    chk("rs_sw", 64'(bus4.Switching), 64'd0);
    chk("rs_idle", 64'(bus4.Idle), 64'd1);
    chk("rs_ready", 64'(bus4.ReadyMask), 64'd0);
    chk("rs_pid", 64'(bus4.RunningPID), 64'd0);
    chk("rs_pcout", 64'(bus4.PCOut), 64'd0);
    chk("rs_off", 64'(bus4.MemOffset), 64'd0);
    step();
    rst = 1'b0;
    cnt_pl = 0;
    repeat (4) begin
      step();
      if (bus4.PCLoad) cnt_pl++;
    end
    chk("rs_no_pcload", 64'(cnt_pl), 64'd0);
    chk("rs_idle_after", 64'(bus4.Idle), 64'd1);

    // NPROC=5: out-of-range CreatePID ignored, wraparound search modulo 5
    do_reset();
    bus5.Create = 1; bus5.CreatePID = 3'd5; bus5.CreatePC = 32'h55;
    step();
    bus5.CreatePID = 3'd7;
    step();
    bus5.Create = 0;
    chk("n5_oob_ignored", 64'(bus5.ReadyMask), 64'd0);
    bus5.Create = 1; bus5.CreatePID = 3'd4; bus5.CreatePC = 32'h44;
    step();
    bus5.Create = 0;
    chk("n5_ready4", 64'(bus5.ReadyMask), 64'b10000);
    bus5.Enable = 1;
    step();
    step();
    chk("n5_load_pl", 64'(bus5.PCLoad), 64'd1);
    chk("n5_load_pc", 64'(bus5.PCOut), 64'h44);
    chk("n5_load_pid", 64'(bus5.RunningPID), 64'd4);
    chk("n5_load_off", 64'(bus5.MemOffset), 64'd1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/process_scheduler.md
PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32: PC/offset width.
REQ-002 SHALL have parameter NPROC, default 4 (legal 2..16): process slots.
REQ-003 SHALL have parameter PID_W, default 2: ceil(log2(NPROC)).
REQ-004 SHALL have parameter QUANTUM, default 64 (legal >=2): cycles per time slice.
REQ-005 SHALL have parameter PAGE_WORDS, default 256: memory words per process partition.
REQ-006 SHALL have port Clock, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port Enable, input, 1: preemptive scheduling on.
REQ-009 SHALL have port CurrentPC, input, DATA_W: next-PC value of the running process.
REQ-010 SHALL have ports Create (input, 1), CreatePID (input, PID_W) and CreatePC (input, DATA_W): register a process entry point.
REQ-011 SHALL have ports Kill (input, 1) and Yield (input, 1): the running process terminates or gives up the CPU.
REQ-012 SHALL have ports PCLoad (output, 1) and PCOut (output, DATA_W): force the processor PC.
REQ-013 SHALL have ports RunningPID (output, PID_W) and MemOffset (output, DATA_W): the data-memory shift.
REQ-014 SHALL have ports ReadyMask (output, NPROC), Idle (output, 1) and Switching (output, 1).

Function
REQ-015 SHALL hold a context table of NPROC saved PCs, plus one ready bit per slot driven on ReadyMask.
REQ-016 SHALL implement the FSM states IDLE, RUN, SAVE, SELECT and LOAD.
REQ-017 IDLE SHALL go to SELECT when Enable=1 and ReadyMask is not 0; otherwise it SHALL stay in IDLE.
REQ-018 RUN SHALL increment the quantum counter each cycle while Enable=1 and hold it while Enable=0.
REQ-019 RUN SHALL go to SAVE on Yield, on Kill, or when the counter equals QUANTUM-1 with Enable=1.
REQ-020 SAVE SHALL clear ready[RunningPID] if Kill caused the exit; otherwise it SHALL write CurrentPC, sampled in the exit cycle, to table[RunningPID].
REQ-021 SELECT SHALL search round-robin from RunningPID+1 mod NPROC, wrapping, and include RunningPID last.
REQ-022 SELECT SHALL take the first ready slot, or go to IDLE if none is ready.
REQ-023 LOAD SHALL set RunningPID to the selected slot, drive PCOut=table[slot] and PCLoad=1 for exactly one cycle, clear the counter, then go to RUN.
REQ-024 Switch latency SHALL be: exit event in cycle N, SAVE in N+1, SELECT in N+2, LOAD (PCLoad=1) in N+3, RUN in N+4.
REQ-025 Switching SHALL be 1 in SAVE, SELECT and LOAD; Idle SHALL be 1 in IDLE only.
REQ-026 MemOffset SHALL equal RunningPID*PAGE_WORDS, zero-extended to DATA_W and registered with RunningPID.
REQ-027 PCOut SHALL hold its last value outside LOAD.
REQ-028 Create SHALL, in any state, write CreatePC to table[CreatePID] and set ready[CreatePID], except in the cases of REQ-029 and REQ-030.
REQ-029 Create SHALL be ignored when CreatePID>=NPROC.
REQ-030 Create SHALL be ignored when CreatePID=RunningPID and the state is RUN or SAVE.
REQ-031 Yield or Kill outside RUN SHALL be ignored; Kill SHALL take priority over Yield and over quantum expiry in the same cycle.
REQ-032 Enable falling in SAVE, SELECT or LOAD SHALL NOT abort the switch in progress.
REQ-033 A Create in the same cycle as SELECT SHALL be visible to that search.

Reset
REQ-034 Reset SHALL force IDLE, all table entries 0, ReadyMask=0 and counter=0.
REQ-035 Reset SHALL force RunningPID=0, MemOffset=0, PCOut=0, PCLoad=0, Idle=1 and Switching=0.
REQ-036 Reset asserted mid-switch SHALL discard the switch; PCLoad SHALL NOT pulse after reset is released.

Verification
REQ-037 With NPROC=4, QUANTUM=8 and PAGE_WORDS=256: Create PID1 PC=0x40, then Enable=1 -> PCLoad pulse 3 cycles later with PCOut=0x40, RunningPID=1 and MemOffset=256.
REQ-038 PIDs 0 and 2 ready at 0x10 and 0x80, with PID0 running: 8 RUN cycles with CurrentPC=0x17 -> table[0]=0x17, PCOut=0x80, RunningPID=2 and MemOffset=512.
REQ-039 Only PID3 is ready and running, and Yield occurs with CurrentPC=0x99 -> PID3 is reloaded with PCOut=0x99 and ReadyMask=1000.
REQ-040 Kill and Yield in the same cycle with PID1 as the only ready process -> ReadyMask=0000, then IDLE with Idle=1 and no PCLoad.
REQ-041 Enable=0 during RUN for 20 cycles -> no preemption; Enable=1 -> preemption 8 counted cycles later. Create with CreatePID=5 is not applicable for PID_W=2; test it with NPROC=5 -> ignored.
REQ-042 Reset asserted in the SELECT cycle -> all outputs at reset values next cycle and no PCLoad pulse.
